// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encodings,
// word geometry and the latency counter width.
package instr_mem_responder_pkg;

  // Fetch FSM states; the encodings are fixed so they can be probed externally.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  // Bytes per instruction word.
  localparam int IMEM_WORD_BYTES = 4;

  // Width of the latency down-counter; covers LATENCY-2 for LATENCY up to 15.
  localparam int IMEM_CNT_W = 4;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/imem_latency_counter.sv
// Loadable down-counter that measures the wait phase of a fetch. It stops
// at zero and flags that condition so the FSM knows the wait is over.
module imem_latency_counter
  import instr_mem_responder_pkg::*;
#(
  parameter int W = IMEM_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a load wins over a decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/instr_mem_responder.sv
// Responder for the CPU instruction-fetch port. A request is accepted in
// IDLE, BUSYWAIT is held for LATENCY cycles in total, then the aligned
// little-endian word is presented for a single RESP cycle. A byte-wide load
// port fills the store at any time.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic [ADDR_W-1:0] ADDRESS,
  output logic [31:0]       READDATA,
  output logic              BUSYWAIT,
  output logic              ADDR_ERR,
  input  logic              LOADEN,
  input  logic [ADDR_W-1:0] LOADADDR,
  input  logic [7:0]        LOADDATA
);

  localparam int WADDR_W = ADDR_W - 2;

  // Counter preload: the accepting edge and the RESP-entry edge account for
  // two of the LATENCY cycles, the counter covers the rest.
  localparam logic [IMEM_CNT_W-1:0] CNT_LOAD =
    (LATENCY > 1) ? IMEM_CNT_W'(LATENCY - 2) : '0;

  // Byte store; deliberately not reset so a loaded program survives RESET.
  logic [7:0] mem [0:MEM_BYTES-1];

  imem_state_e        state_q, state_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic               err_q, err_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               addr_err_q, addr_err_d;
  logic               busywait;

  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_done;

  logic [WADDR_W-1:0] rd_waddr;
  logic [7:0]         rd_bytes [IMEM_WORD_BYTES];
  logic [31:0]        rd_word;

  imem_latency_counter #(
    .W(IMEM_CNT_W)
  ) u_latency_counter (
    .clk     (CLK),
    .rst_n   (RESET),
    .load    (cnt_load),
    .load_val(CNT_LOAD),
    .dec     (cnt_dec),
    .done    (cnt_done)
  );

  // Program-load write port; active in every FSM state.
  always_ff @(posedge CLK) begin
    if (LOADEN) begin
      mem[LOADADDR] <= LOADDATA;
    end
  end

  // Word to read at RESP entry: with LATENCY==1 the entry happens on the
  // accepting edge, so the live address is used instead of the latched one.
  always_comb begin
    rd_waddr = waddr_q;
    if (state_q == ST_IDLE) begin
      rd_waddr = ADDRESS[ADDR_W-1:2];
    end
  end

  // Gather the four bytes of the addressed word, lowest address first.
  for (genvar gi = 0; gi < IMEM_WORD_BYTES; gi++) begin : g_rd_byte
    assign rd_bytes[gi] = mem[{rd_waddr, 2'(gi)}];
  end

  assign rd_word = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};

  // Fetch FSM next-state, request latching and response capture.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    err_d      = err_q;
    readdata_d = readdata_q;
    addr_err_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    busywait   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busywait = READ;
        if (READ) begin
          waddr_d = ADDRESS[ADDR_W-1:2];
          err_d   = is_misaligned(ADDRESS[1:0]);
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            readdata_d = rd_word;
            addr_err_d = is_misaligned(ADDRESS[1:0]);
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        busywait = 1'b1;
        if (!READ) begin
          // Requester gave up: drop the fetch without touching READDATA.
          state_d = ST_IDLE;
        end else if (cnt_done) begin
          state_d    = ST_RESP;
          readdata_d = rd_word;
          addr_err_d = err_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers; the asynchronous reset clears them at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      waddr_q    <= '0;
      err_q      <= 1'b0;
      readdata_q <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      err_q      <= err_d;
      readdata_q <= readdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign READDATA = readdata_q;
  assign ADDR_ERR = addr_err_q;
  assign BUSYWAIT = busywait;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a LATENCY=5 instance carries most
// scenarios, a LATENCY=1 instance checks the shortest fetch.
module tb_instr_mem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              read_req;
  logic              read1_req;
  logic [ADDR_W-1:0] address;
  logic              loaden;
  logic [ADDR_W-1:0] loadaddr;
  logic [7:0]        loaddata;

  logic [31:0] readdata;
  logic        busywait;
  logic        addr_err;
  logic [31:0] readdata1;
  logic        busywait1;
  logic        addr_err1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .MEM_BYTES(1024),
    .ADDR_W   (ADDR_W),
    .LATENCY  (LAT)
  ) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .READ    (read_req),
    .ADDRESS (address),
    .READDATA(readdata),
    .BUSYWAIT(busywait),
    .ADDR_ERR(addr_err),
    .LOADEN  (loaden),
    .LOADADDR(loadaddr),
    .LOADDATA(loaddata)
  );

  instr_mem_responder #(
    .MEM_BYTES(1024),
    .ADDR_W   (ADDR_W),
    .LATENCY  (1)
  ) dut1 (
    .CLK     (clk),
    .RESET   (rst_n),
    .READ    (read1_req),
    .ADDRESS (address),
    .READDATA(readdata1),
    .BUSYWAIT(busywait1),
    .ADDR_ERR(addr_err1),
    .LOADEN  (loaden),
    .LOADADDR(loadaddr),
    .LOADDATA(loaddata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    loaden   = 1'b1;
    loadaddr = a;
    loaddata = d;
    step();
    loaden   = 1'b0;
  endtask

  // One complete fetch on the LATENCY=5 instance.
  task automatic fetch(input string tag, input logic [ADDR_W-1:0] a,
                       input logic [31:0] exp_word, input logic exp_err);
    int n;
    read_req = 1'b1;
    address  = a;
    #1;
    n = 0;
    while (busywait && n < 40) begin
      n++;
      step();
    end
    check_eq({tag, " busy cycles"}, 32'(n), 32'(LAT));
    check_eq({tag, " data"}, readdata, exp_word);
    check_eq({tag, " addr_err"}, 32'(addr_err), 32'(exp_err));
    read_req = 1'b0;
    step();
    check_eq({tag, " err clears"}, 32'(addr_err), 32'd0);
    check_eq({tag, " data holds"}, readdata, exp_word);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    read_req  = 1'b0;
    read1_req = 1'b0;
    address   = '0;
    loaden    = 1'b0;
    loadaddr  = '0;
    loaddata  = '0;
    #2;
    check_eq("reset readdata", readdata, 32'h0);
    check_eq("reset busywait", 32'(busywait), 32'd0);
    check_eq("reset addr_err", 32'(addr_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Program image: word 0 = 0x02000500, word 4 = 0x44332211.
    load_byte(10'd0, 8'h00);
    load_byte(10'd1, 8'h05);
    load_byte(10'd2, 8'h00);
    load_byte(10'd3, 8'h02);
    load_byte(10'd4, 8'h11);
    load_byte(10'd5, 8'h22);
    load_byte(10'd6, 8'h33);
    load_byte(10'd7, 8'h44);

    fetch("fetch0", 10'd0, 32'h02000500, 1'b0);
    fetch("misalign6", 10'd6, 32'h44332211, 1'b1);

    // Back-to-back: READ stays high, address moves to 4 after the first RESP.
    read_req = 1'b1;
    address  = 10'd0;
    #1;
    n = 0;
    while (busywait && n < 40) begin
      n++;
      step();
    end
    check_eq("b2b first data", readdata, 32'h02000500);
    address = 10'd4;
    step();
    check_eq("b2b busy rises", 32'(busywait), 32'd1);
    n = 1;
    while (busywait && n < 40) begin
      n++;
      step();
    end
    check_eq("b2b resp spacing", 32'(n), 32'(LAT + 1));
    check_eq("b2b second data", readdata, 32'h44332211);
    read_req = 1'b0;
    step();

    // Abort: READ dropped in the second WAIT cycle.
    read_req = 1'b1;
    address  = 10'd0;
    step();
    step();
    read_req = 1'b0;
    step();
    check_eq("abort busy low", 32'(busywait), 32'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      step();
    end
    check_eq("abort data kept", readdata, 32'h44332211);

    // LATENCY=1 instance: one busy cycle, response in the next cycle.
    read1_req = 1'b1;
    address   = 10'd4;
    #1;
    check_eq("lat1 busy high", 32'(busywait1), 32'd1);
    step();
    check_eq("lat1 busy low", 32'(busywait1), 32'd0);
    check_eq("lat1 data", readdata1, 32'h44332211);
    read1_req = 1'b0;
    step();
    check_eq("lat1 idle busy", 32'(busywait1), 32'd0);

    // Reset pulse in the middle of WAIT.
    read_req = 1'b1;
    address  = 10'd4;
    step();
    step();
    #2;
    read_req = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("midwait rst busy", 32'(busywait), 32'd0);
    check_eq("midwait rst data", readdata, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    fetch("post-reset", 10'd4, 32'h44332211, 1'b0);

    // Load into byte 0 on the RESP-entry edge: old bytes returned now.
    read_req = 1'b1;
    address  = 10'd0;
    #1;
    for (int i = 0; i < LAT - 1; i++) begin
      step();
    end
    loaden   = 1'b1;
    loadaddr = 10'd0;
    loaddata = 8'hAA;
    step();
    loaden   = 1'b0;
    check_eq("rbw resp busy", 32'(busywait), 32'd0);
    check_eq("rbw old data", readdata, 32'h02000500);
    read_req = 1'b0;
    step();
    fetch("rbw new data", 10'd0, 32'h020005AA, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
